alu_result_buffer: RTL and testbench

Downstream stage of the 4-bit ALU. It captures each ALU result (8-bit out plus five status flags and the opcode) through a valid/ready handshake into a small first-word-fall-through FIFO, and presents the entries to the consumer in order. It also maintains a sticky overflow status bit and a saturating count of results discarded for unsupported opcodes, so control logic can drain results at its own rate.

---
 rtl/alu_result_buffer.sv | 98 +++++++++
 tb/tb_alu_result_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FWFT result FIFO behind the 4-bit ALU with sticky overflow and illegal-opcode count
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_out,
  input  logic                       in_carry_borrow,
  input  logic                       in_zero,
  input  logic                       in_parity,
  input  logic                       in_sign,
  input  logic                       in_overflow,
  input  logic [2:0]                 in_opcode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [4:0]                 out_flags,
  output logic [2:0]                 out_opcode,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sticky_overflow,
  input  logic                       sticky_clear,
  output logic [CNT_W-1:0]           illegal_count
);

  localparam int AW = $clog2(DEPTH);

  // Entry layout: {opcode[2:0], flags[4:0], data[7:0]}
  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] illegal_q, illegal_d;

  logic        full, empty, accept, legal, push, pop;
  logic [15:0] head;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign legal  = (in_opcode[2:1] == 2'b00);
  assign accept = in_valid && !full;
  assign push   = accept && legal;
  assign pop    = !empty && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    sticky_d  = sticky_q;
    illegal_d = illegal_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    // Set has priority over clear so a same-cycle overflow is never lost
    if (sticky_clear)             sticky_d = 1'b0;
    if (push && in_overflow)      sticky_d = 1'b1;
    if (accept && !legal && (illegal_q != {CNT_W{1'b1}}))
      illegal_d = illegal_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      illegal_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= {in_opcode, in_overflow, in_sign, in_parity, in_zero,
                          in_carry_borrow, in_out};
  end

  assign head            = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign in_ready        = !full;
  assign out_valid       = !empty;
  assign out_data        = head[7:0];
  assign out_flags       = head[12:8];
  assign out_opcode      = head[15:13];
  assign count           = count_q;
  assign sticky_overflow = sticky_q;
  assign illegal_count   = illegal_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_out;
  logic       in_carry_borrow, in_zero, in_parity, in_sign, in_overflow;
  logic [2:0] in_opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_flags;
  logic [2:0] out_opcode;
  logic [2:0] count;
  logic       sticky_overflow;
  logic       sticky_clear;
  logic [7:0] illegal_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_out(in_out),
    .in_carry_borrow(in_carry_borrow), .in_zero(in_zero), .in_parity(in_parity),
    .in_sign(in_sign), .in_overflow(in_overflow), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_opcode(out_opcode), .count(count),
    .sticky_overflow(sticky_overflow), .sticky_clear(sticky_clear),
    .illegal_count(illegal_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed pop is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected nothing",
                 {out_opcode, out_flags, out_data});
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({out_opcode, out_flags, out_data} != e) begin
          errors++;
          $display("FAIL pop_entry: got %0h expected %0h",
                   {out_opcode, out_flags, out_data}, e);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [4:0] f, input logic [2:0] op);
    bit done = 0;
    in_out = d;
    {in_overflow, in_sign, in_parity, in_zero, in_carry_borrow} = f;
    in_opcode = op;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (op[2:1] == 2'b00) exp_q.push_back({op, f, d});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    check("drain_empty", count, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_out = 0; in_carry_borrow = 0; in_zero = 0;
    in_parity = 0; in_sign = 0; in_overflow = 0; in_opcode = 0;
    out_ready = 0; sticky_clear = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_opcode", out_opcode, 0);
    check("rst_count", count, 0);
    check("rst_sticky", sticky_overflow, 0);
    check("rst_illegal", illegal_count, 0);

    // Single add
    push(8'h0C, 5'b00101, 3'b000);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'h0C);
    check("single_flags", out_flags, 5'b00101);
    check("single_count", count, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("single_pop_count", count, 0);
    check("single_pop_data", out_data, 0);

    // Fill and backpressure
    for (int v = 1; v <= 4; v++) push(8'(v), 5'b00000, 3'b000);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    in_out = 8'd5; in_opcode = 3'b000;
    {in_overflow, in_sign, in_parity, in_zero, in_carry_borrow} = 5'b00010;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("blocked_count", count, 4);
    check("blocked_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_pop_in_ready", in_ready, 1);
    check("after_pop_count", count, 3);
    push(8'd5, 5'b00010, 3'b000);
    check("refill_count", count, 4);
    drain();

    // Wrap-around with continuous consumer
    out_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      push(8'(8'h30 + v), {1'b0, 4'(v)}, 3'b001);
      checks++;
      if (count > 2) begin
        errors++;
        $display("FAIL wrap_count: got %0d expected <=2", count);
      end
    end
    drain();

    // Illegal opcodes and saturation
    push(8'hFF, 5'b10000, 3'b010);
    push(8'hFF, 5'b10000, 3'b111);
    check("illegal_in_ready", in_ready, 1);
    check("illegal_count_stays0", count, 0);
    check("illegal_cnt2", illegal_count, 2);
    check("illegal_no_sticky", sticky_overflow, 0);
    for (int i = 0; i < 253; i++) push(8'h00, 5'b00000, 3'b100);
    check("illegal_cnt255", illegal_count, 255);
    push(8'h00, 5'b00000, 3'b101);
    check("illegal_sat", illegal_count, 255);

    // Sticky overflow
    push(8'h7F, 5'b10000, 3'b001);
    check("sticky_set", sticky_overflow, 1);
    sticky_clear = 1'b1;
    push(8'h80, 5'b11000, 3'b001);
    sticky_clear = 1'b0;
    check("sticky_set_wins", sticky_overflow, 1);
    sticky_clear = 1'b1;
    @(posedge clk); #1;
    sticky_clear = 1'b0;
    check("sticky_cleared", sticky_overflow, 0);
    drain();

    // Mid-operation reset
    push(8'h11, 5'b10000, 3'b000);
    push(8'h22, 5'b00000, 3'b001);
    push(8'h33, 5'b00000, 3'b000);
    check("pre_rst_count", count, 3);
    rst = 1'b1; in_valid = 1'b1; in_out = 8'hAA; in_opcode = 3'b000;
    {in_overflow, in_sign, in_parity, in_zero, in_carry_borrow} = 5'b10000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sticky", sticky_overflow, 0);
    check("mid_rst_illegal", illegal_count, 0);
    check("mid_rst_data", out_data, 0);
    push(8'h5A, 5'b00001, 3'b000);
    check("post_rst_head", out_data, 8'h5A);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
